// File: rtl/i2c_mem_master.sv
// Single-byte read/write I2C master for the 16-byte memory slave.
// A command is turned into START/address/data/STOP frames on open-drain SCL/SDA.
module i2c_mem_master #(
    parameter logic [6:0] SLAVE_ADR = 7'b001_0000,
    parameter int         CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_adr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int            QW    = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] START  = 4'd1;
    localparam logic [3:0] ADDR_W = 4'd2;
    localparam logic [3:0] MADR   = 4'd3;
    localparam logic [3:0] WDATA  = 4'd4;
    localparam logic [3:0] RSTART = 4'd5;
    localparam logic [3:0] ADDR_R = 4'd6;
    localparam logic [3:0] RDATA  = 4'd7;
    localparam logic [3:0] STOP   = 4'd8;
    localparam logic [3:0] RESP   = 4'd9;

    logic [3:0]    state, succ;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [3:0]    bitcnt;
    logic          rw_r, nack;
    logic [7:0]    adr_r, wdata_r, rx, tx_byte;
    logic          tick, is_byte, is_tx, mid;

    assign tick = (qcnt == QLAST);
    assign mid  = q[0] ^ q[1];

    // Byte to shift out and the state following the current frame element.
    always_comb begin
        tx_byte = 8'h00;
        is_byte = 1'b1;
        succ    = IDLE;
        case (state)
            START:   begin is_byte = 1'b0; succ = ADDR_W; end
            ADDR_W:  begin tx_byte = {SLAVE_ADR, 1'b0}; succ = nack ? STOP : MADR; end
            MADR:    begin tx_byte = adr_r; succ = nack ? STOP : (rw_r ? RSTART : WDATA); end
            WDATA:   begin tx_byte = wdata_r; succ = STOP; end
            RSTART:  begin is_byte = 1'b0; succ = ADDR_R; end
            ADDR_R:  begin tx_byte = {SLAVE_ADR, 1'b1}; succ = nack ? STOP : RDATA; end
            RDATA:   succ = STOP;
            STOP:    begin is_byte = 1'b0; succ = RESP; end
            default: is_byte = 1'b0;
        endcase
        is_tx = is_byte && (state != RDATA);
    end

    always_comb begin
        scl_o  = 1'b1;
        sda_oe = 1'b0;
        case (state)
            START:  begin scl_o = (q != 2'd3); sda_oe = (q != 2'd0); end
            RSTART: begin scl_o = mid; sda_oe = q[1]; end
            STOP:   begin scl_o = (q != 2'd0); sda_oe = !q[1]; end
            ADDR_W, MADR, WDATA, ADDR_R: begin
                scl_o  = mid;
                // bit 8 is the ACK slot: released so the slave can answer
                sda_oe = !bitcnt[3] && !tx_byte[~bitcnt[2:0]];
            end
            RDATA:   scl_o = mid;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            qcnt      <= '0;
            q         <= 2'd0;
            bitcnt    <= 4'd0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            nack      <= 1'b0;
            rx        <= 8'h00;
            rw_r      <= 1'b0;
            adr_r     <= 8'h00;
            wdata_r   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        rw_r      <= cmd_rw;
                        adr_r     <= cmd_adr;
                        wdata_r   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        nack      <= 1'b0;
                        rx        <= 8'h00;
                        qcnt      <= '0;
                        q         <= 2'd0;
                        bitcnt    <= 4'd0;
                        state     <= START;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    qcnt <= tick ? '0 : qcnt + 1'b1;
                    if (tick) begin
                        q <= q + 2'd1;
                        // sda_i sampled in the last cycle of q2
                        if (q == 2'd2 && is_tx && bitcnt == 4'd8 && sda_i)
                            nack <= 1'b1;
                        if (q == 2'd2 && state == RDATA && !bitcnt[3])
                            rx <= {rx[6:0], sda_i};
                        if (q == 2'd3) begin
                            if (is_byte && bitcnt != 4'd8) begin
                                bitcnt <= bitcnt + 4'd1;
                            end else begin
                                bitcnt <= 4'd0;
                                state  <= succ;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_nack  = rsp_valid && nack;
    assign rsp_rdata = (rsp_valid && rw_r && !nack) ? rx : 8'h00;
endmodule

// File: tb/tb_i2c_mem_master.sv
// Bench for i2c_mem_master: bus-level memory slave model, table vectors,
// randomized commands against a memory/latency reference, and corner sequences.
module tb_i2c_mem_master;
    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [7:0] cmd_adr, cmd_wdata;
    logic       rsp_valid, rsp_nack, busy, scl_o, sda_oe;
    logic [7:0] rsp_rdata;

    logic       s_drv;
    wire        sda = !(sda_oe || s_drv);

    i2c_mem_master #(.SLAVE_ADR(7'h10), .CLK_DIV(Q)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda)
    );

    always #5 clk = ~clk;

    // Memory slave: reacts to bus edges seen at the falling clk edge.
    localparam int PH_IDLE = 0, PH_ADR = 1, PH_MADR = 2, PH_WR = 3, PH_RD = 4;
    logic [6:0] s_adr;
    logic [7:0] s_mem [16];
    int         s_starts;
    logic       s_mack;

    initial begin : slave
        logic       p_scl, p_sda, cur, s_ack;
        int         s_bit, s_ph, s_next;
        logic [7:0] s_sh, s_rd;
        logic [3:0] s_ptr;
        for (int i = 0; i < 16; i++) s_mem[i] = 8'h00;
        p_scl = 1'b1; p_sda = 1'b1; s_drv = 1'b0; s_starts = 0; s_mack = 1'b0;
        s_bit = 0; s_ph = PH_IDLE; s_next = PH_IDLE; s_sh = 8'h00; s_rd = 8'h00;
        s_ptr = 4'd0; s_ack = 1'b0;
        forever begin
            @(negedge clk);
            cur = sda;
            if (scl_o && p_scl && p_sda && !cur) begin
                s_starts++; s_ph = PH_ADR; s_bit = 0; s_drv = 1'b0;
            end else if (scl_o && p_scl && !p_sda && cur) begin
                s_ph = PH_IDLE; s_drv = 1'b0;
            end else if (s_ph != PH_IDLE && scl_o && !p_scl) begin
                if (s_bit < 8) begin
                    if (s_ph != PH_RD) s_sh = {s_sh[6:0], cur};
                    s_bit++;
                end else if (s_bit == 8) begin
                    if (s_ph == PH_RD) s_mack = cur;
                    s_bit = 9;
                end
            end else if (s_ph != PH_IDLE && !scl_o && p_scl) begin
                if (s_ph == PH_RD) begin
                    if (s_bit >= 1 && s_bit <= 7) s_drv = !s_rd[7 - s_bit];
                    else if (s_bit == 8) s_drv = 1'b0;
                    else if (s_bit == 9) begin s_drv = 1'b0; s_ph = PH_IDLE; end
                end else if (s_bit == 8) begin
                    case (s_ph)
                        PH_ADR: begin
                            s_ack = (s_sh[7:1] == s_adr);
                            s_next = s_sh[0] ? PH_RD : PH_MADR;
                        end
                        PH_MADR: begin
                            s_ack = (s_sh < 8'd16); s_ptr = s_sh[3:0]; s_next = PH_WR;
                        end
                        default: begin
                            s_mem[s_ptr] = s_sh; s_ack = 1'b1; s_next = PH_IDLE;
                        end
                    endcase
                    s_drv = s_ack;
                end else if (s_bit == 9) begin
                    s_bit = 0; s_drv = 1'b0;
                    s_ph = s_ack ? s_next : PH_IDLE;
                    if (s_ph == PH_RD) begin s_rd = s_mem[s_ptr]; s_drv = !s_rd[7]; end
                end
            end
            p_scl = scl_o; p_sda = cur;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic rw, input logic [7:0] adr, input logic [7:0] wd,
                          output logic nk, output logic [7:0] rd, output int lat,
                          output int starts);
        int t = 0;
        int s0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        s0 = s_starts;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_adr = adr; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_rw = 1'($urandom); cmd_adr = 8'($urandom); cmd_wdata = 8'($urandom);
        chk("busy_on", busy, 1);
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        if (!rsp_valid) lat = -1;
        nk = rsp_nack; rd = rsp_rdata; starts = s_starts - s0;
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("busy_off", busy, 0);
        chk("ready_back", cmd_ready, 1);
    endtask

    typedef struct {
        logic       rw;
        logic [7:0] adr, wd;
        logic [6:0] sadr;
        logic       nk;
        logic [7:0] rd;
        int         lat;
        int         starts;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] ref_mem [16];

    initial begin : main
        logic       nk, e_nk, rw, bad, seen;
        logic [7:0] rd, e_rd, adr, wd;
        int         lat, e_lat, st, s0, t;

        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_adr = 8'h00; cmd_wdata = 8'h00;
        s_adr = 7'h10;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        vecs[0] = '{1'b0, 8'h03, 8'hA5, 7'h10, 1'b0, 8'h00, 465, 1};
        vecs[1] = '{1'b1, 8'h03, 8'h00, 7'h10, 1'b0, 8'hA5, 625, 2};
        vecs[2] = '{1'b0, 8'h20, 8'h5A, 7'h10, 1'b1, 8'h00, 321, 1};
        vecs[3] = '{1'b0, 8'h03, 8'h5A, 7'h11, 1'b1, 8'h00, 177, 1};
        vecs[4] = '{1'b1, 8'h03, 8'h00, 7'h10, 1'b0, 8'hA5, 625, 2};
        vecs[5] = '{1'b1, 8'h20, 8'h00, 7'h10, 1'b1, 8'h00, 321, 1};
        vecs[6] = '{1'b1, 8'h03, 8'h00, 7'h11, 1'b1, 8'h00, 177, 1};
        vecs[7] = '{1'b0, 8'h0F, 8'h3C, 7'h10, 1'b0, 8'h00, 465, 1};
        vecs[8] = '{1'b1, 8'h0F, 8'h00, 7'h10, 1'b0, 8'h3C, 625, 2};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_scl", scl_o, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_nack", rsp_nack, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        chk("ready_rise", cmd_ready, 1);

        for (int i = 0; i < 9; i++) begin
            s_adr = vecs[i].sadr;
            do_cmd(vecs[i].rw, vecs[i].adr, vecs[i].wd, nk, rd, lat, st);
            chk($sformatf("v%0d_nack", i), nk, vecs[i].nk);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_starts", i), st, vecs[i].starts);
            if (vecs[i].rw && !vecs[i].nk) chk($sformatf("v%0d_master_ack", i), s_mack, 1);
            if (!vecs[i].rw && !vecs[i].nk) ref_mem[vecs[i].adr[3:0]] = vecs[i].wd;
            if (!vecs[i].rw && vecs[i].adr < 8'd16)
                chk($sformatf("v%0d_mem", i), s_mem[vecs[i].adr[3:0]], ref_mem[vecs[i].adr[3:0]]);
        end

        for (int i = 0; i < 10; i++) begin
            rw  = 1'($urandom_range(0, 1));
            adr = 8'($urandom_range(0, 19));
            wd  = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            s_adr = bad ? 7'h11 : 7'h10;
            e_nk  = bad || (adr > 8'd15);
            e_rd  = (!e_nk && rw) ? ref_mem[adr[3:0]] : 8'h00;
            e_lat = bad ? 44 * Q + 1 : (adr > 8'd15) ? 80 * Q + 1 : rw ? 156 * Q + 1 : 116 * Q + 1;
            if (!e_nk && !rw) ref_mem[adr[3:0]] = wd;
            do_cmd(rw, adr, wd, nk, rd, lat, st);
            chk($sformatf("r%0d_nack", i), nk, e_nk);
            chk($sformatf("r%0d_rdata", i), rd, e_rd);
            chk($sformatf("r%0d_lat", i), lat, e_lat);
        end
        s_adr = 7'h10;

        // Reset in WDATA bit 4, q1
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_adr = 8'h05; cmd_wdata = 8'h77;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (93 * Q) @(negedge clk);
        chk("mid_scl_high", scl_o, 1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_scl", scl_o, 1);
        chk("mid_rst_sda_oe", sda_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        seen = 1'b0;
        repeat (700) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        chk("mid_no_rsp", seen, 0);
        chk("mid_mem5_kept", s_mem[5], ref_mem[5]);
        do_cmd(1'b0, 8'h05, 8'hC3, nk, rd, lat, st);
        ref_mem[5] = 8'hC3;
        chk("post_rst_nack", nk, 0);
        chk("post_rst_lat", lat, 465);
        chk("post_rst_mem5", s_mem[5], 8'hC3);

        // Back-to-back with cmd_valid held high throughout
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        s0 = s_starts;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_adr = 8'h00; cmd_wdata = 8'h11;
        @(negedge clk);
        cmd_adr = 8'h0F; cmd_wdata = 8'hEE;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        chk("b2b_lat1", lat, 465);
        @(negedge clk);
        chk("b2b_ready", cmd_ready, 1);
        @(negedge clk);
        chk("b2b_second_busy", busy, 1);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        chk("b2b_lat2", lat, 465);
        chk("b2b_nack2", rsp_nack, 0);
        ref_mem[0] = 8'h11; ref_mem[15] = 8'hEE;
        repeat (3) @(negedge clk);
        chk("b2b_starts", s_starts - s0, 2);

        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), s_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_mem_master.md
# i2c_mem_master

Synchronous single-clock I2C master that runs single-byte write and single-byte read transactions against the team's 7-bit-addressed I2C memory slave, which has a 16-byte memory. A simple command/response handshake on the system side is converted into START, slave address, memory address, data and STOP sequences on an open-drain SCL/SDA pair. It is the sequencer placed in front of the slave model in bus-level benches and in SoC top levels that configure the slave's register file.

## Interface
- SLAVE_ADR, 7'b001_0000, 7-bit I2C address placed in every address byte
- CLK_DIV, 4, clk cycles per SCL quarter-period (minimum 2); one bit = 4*CLK_DIV cycles
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_rw  in  1  1 = read, 0 = write
- cmd_adr  in  8  slave memory address
- cmd_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  8  read byte, valid with rsp_valid for reads; 8'h00 for writes or on NACK
- rsp_nack  out  1  valid with rsp_valid; 1 = any slave ACK slot sampled high
- busy  out  1  high from acceptance through the rsp_valid cycle
- scl_o  out  1  SCL drive; 1 = release (pulled high), 0 = drive low
- sda_oe  out  1  1 = drive SDA low, 0 = release
- sda_i  in  1  resolved SDA level, sampled directly with no synchronizer

## Operation
- Reset values: scl_o=1, sda_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=8'h00, rsp_nack=0, busy=0. State is IDLE and the quarter counter is 0. cmd_ready rises the first cycle after rst falls.
- On acceptance, cmd_rw, cmd_adr and cmd_wdata are latched. Inputs are don't-care afterwards.
- Quarter tick: a counter from 0 to CLK_DIV-1 pulses once per quarter. All bus changes happen on tick boundaries.
- Bit slot (4 quarters):
  - q0: scl_o=0, update sda_oe.
  - q1 and q2: scl_o=1. sda_i is sampled in the last cycle of q2.
  - q3: scl_o=0.
- Byte slot: 8 bits MSB first, then an ACK bit.
  - When the master transmits, it releases SDA in the ACK bit and samples sda_i.
  - When the master receives, it releases SDA for the data bits. In the ACK bit it releases SDA, which sends a NACK because the master reads only one byte.
- START (4 quarters): q0 SDA released, SCL high; q1 SDA low; q2 SDA low; q3 SCL low.
- STOP (4 quarters): q0 SCL low, SDA low; q1 SCL high; q2 SDA released; q3 idle-high.
- Repeated start (RSTART, 4 quarters): q0 SCL low, SDA released; q1 SCL high; q2 SDA low; q3 SCL low.
- States: IDLE, START, ADDR_W, MADR, WDATA, RSTART, ADDR_R, RDATA, STOP, RESP.
  - Write path: START, ADDR_W ({SLAVE_ADR,0}), MADR (cmd_adr), WDATA (cmd_wdata), STOP, RESP.
  - Read path: START, ADDR_W, MADR, RSTART, ADDR_R ({SLAVE_ADR,1}), RDATA, STOP, RESP.
- NACK: an ACK sample of 1 in ADDR_W, MADR, WDATA or ADDR_R sets a sticky nack flag. The master finishes that ACK bit and then jumps to STOP; the remaining bytes are skipped. The slave NACKs MADR for addresses above 15.
- RESP (1 cycle):
  - rsp_valid=1 and rsp_nack=flag.
  - rsp_rdata=shifted byte for a successful read, else 8'h00.
  - Next state is IDLE, and cmd_ready is 1 the following cycle.

## Timing
- Q = CLK_DIV clk cycles. Acceptance cycle = cycle 0. START q0 begins at cycle 1.
- Write latency: START 4Q + 3 bytes × 9 bits × 4Q + STOP 4Q = 116Q. rsp_valid is at cycle 116Q+1; with CLK_DIV=4 that is cycle 465.
- Read latency: 4Q + 72Q + 4Q + 72Q + 4Q = 156Q. rsp_valid is at cycle 156Q+1; with CLK_DIV=4 that is cycle 625.
- NACK on ADDR_W: 4Q + 36Q + 4Q = 44Q. rsp_valid is at cycle 44Q+1.
- NACK on MADR: 80Q total. rsp_valid is at cycle 80Q+1.
- Back-to-back commands: the earliest next acceptance is the cycle after RESP, so the minimum bus idle between STOP and the next START is 2 cycles plus the STOP q3 quarter.
- Reset mid-transaction: scl_o=1 and sda_oe=0 the cycle after rst is sampled high. No rsp_valid is issued. The partial frame is abandoned, and the slave resynchronizes on the next START.
- A cmd_valid that is high while busy is ignored and not queued.
- No clock-stretching support: SCL is driven purely by timing, and sda_i is not checked against expected levels except in ACK and RDATA slots.

## Test plan
- Reset then write: cmd_rw=0, cmd_adr=8'h03, cmd_wdata=8'hA5 to a slave at 7'h10 → all ACKs, rsp_valid at cycle 465 (CLK_DIV=4), rsp_nack=0, slave mem[3]=8'hA5.
- Read-back: cmd_rw=1, cmd_adr=8'h03 after the previous write → RSTART observed, rsp_valid at cycle 625, rsp_rdata=8'hA5, rsp_nack=0, SDA released during the master ACK slot.
- Bad memory address: write to cmd_adr=8'h20 → slave NACKs MADR, STOP follows immediately, rsp_valid at cycle 321, rsp_nack=1, rsp_rdata=8'h00.
- Wrong slave: SLAVE_ADR=7'h11 against a slave at 7'h10 → NACK on ADDR_W, rsp_valid at cycle 177, rsp_nack=1, slave memory unchanged.
- Reset mid-frame: assert rst for one cycle during WDATA bit 4 → next cycle scl_o=1, sda_oe=0, busy=0; no rsp_valid; a subsequent full write to 8'h05 completes with rsp_nack=0.
- Back-to-back: hold cmd_valid high with two writes (8'h00←8'h11, 8'h0F←8'hEE) → second accepted the cycle after the first rsp_valid; both bytes present in slave memory; cmd_valid while busy is ignored.
